// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder and its neighbours.
package imem_pkg;

  // Data path width of the fetch bus.
  localparam int unsigned XLEN = 32;

  // Width of the stall pattern and of the pointer that walks it.
  localparam int unsigned STALL_W = 8;
  localparam int unsigned SP_W    = 3;

  // Word returned for faulting fetches (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // Responder FSM states.
  typedef enum logic {
    IMEM_IDLE = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_e;

endpackage

// File: rtl/imem_responder_if.sv
// Core instruction-fetch bus: request handshake plus a response without ready.
interface imem_responder_if;
  import imem_pkg::*;

  logic            io_imem_req_valid;
  logic [XLEN-1:0] io_imem_req_bits_addr;
  logic            io_imem_req_ready;
  logic            io_imem_resp_valid;
  logic [XLEN-1:0] io_imem_resp_bits_data;

  // Core side issues fetches and consumes responses.
  modport master (
    output io_imem_req_valid,
    output io_imem_req_bits_addr,
    input  io_imem_req_ready,
    input  io_imem_resp_valid,
    input  io_imem_resp_bits_data
  );

  // Memory side accepts fetches and returns instruction words.
  modport slave (
    input  io_imem_req_valid,
    input  io_imem_req_bits_addr,
    output io_imem_req_ready,
    output io_imem_resp_valid,
    output io_imem_resp_bits_data
  );
endinterface

// File: rtl/imem_resp_pipe.sv
// Fixed-latency valid/data delay line; data in each stage only changes when a
// valid word moves into it, so the output data holds between responses.
module imem_resp_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [LATENCY-1:0]         valid_q, valid_d;
  logic [LATENCY-1:0][DW-1:0] data_q, data_d;

  // Shift every cycle; a stage captures data only when the word entering it is valid.
  always_comb begin
    valid_d    = '0;
    data_d     = data_q;
    valid_d[0] = in_valid;
    if (in_valid) begin
      data_d[0] = in_data;
    end
    for (int i = 1; i < int'(LATENCY); i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  // Stage registers; reset drops everything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: program image, stall injection, range/alignment
// fault tracking and a fixed-latency response path for the fetch bus.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter logic [31:0] NOP_INST    = imem_pkg::NOP_INST,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic                           clock,
  input  logic                           reset,
  imem_responder_if.slave                bus,
  input  logic                           io_load_valid,
  input  logic [AW-1:0]                  io_load_addr,
  input  logic [31:0]                    io_load_data,
  input  logic                           io_start,
  input  logic [imem_pkg::STALL_W-1:0]   io_stall_mask,
  output logic                           io_fault,
  output logic [31:0]                    io_fault_addr
);

  import imem_pkg::*;

  imem_state_e     state_q, state_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic            req_ready_c;
  logic            accept_c;
  logic [XLEN:0]   diff_c;
  logic [XLEN-1:0] off_c;
  logic            in_range_c;
  logic [AW-1:0]   idx_c;
  logic [XLEN-1:0] rd_data_c;

  // IDLE waits for start; RUN is held until reset and walks the stall pointer.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    case (state_q)
      IMEM_IDLE: begin
        if (io_start) begin
          state_d = IMEM_RUN;
        end
      end
      IMEM_RUN: begin
        sp_d = sp_q + SP_W'(1);
      end
      default: begin
        state_d = IMEM_IDLE;
      end
    endcase
  end

  // Ready follows the live stall mask at the current pointer position.
  always_comb begin
    req_ready_c = (state_q == IMEM_RUN) && !io_stall_mask[sp_q];
    accept_c    = bus.io_imem_req_valid && req_ready_c;
  end

  // Decode: a borrow out of the subtraction means the address is below the base.
  always_comb begin
    diff_c     = {1'b0, bus.io_imem_req_bits_addr} - {1'b0, BASE_ADDR};
    off_c      = diff_c[XLEN-1:0];
    in_range_c = !diff_c[XLEN] && (off_c[1:0] == 2'b00) &&
                 ({2'b00, off_c[XLEN-1:2]} < 32'(DEPTH_WORDS));
    idx_c      = off_c[AW+1:2];
    rd_data_c  = in_range_c ? mem_q[idx_c] : NOP_INST;
  end

  // Sticky fault flag; the address is captured only for the first fault.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (accept_c && !in_range_c) begin
      fault_d = 1'b1;
      if (!fault_q) begin
        fault_addr_d = bus.io_imem_req_bits_addr;
      end
    end
  end

  // Control and fault registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IMEM_IDLE;
      sp_q         <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Program image; not reset, and a same-edge fetch sees the previous word.
  always_ff @(posedge clock) begin
    if (io_load_valid) begin
      mem_q[io_load_addr] <= io_load_data;
    end
  end

  imem_resp_pipe #(
    .LATENCY (LATENCY),
    .DW      (XLEN)
  ) u_resp_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (accept_c),
    .in_data   (rd_data_c),
    .out_valid (bus.io_imem_resp_valid),
    .out_data  (bus.io_imem_resp_bits_data)
  );

  assign bus.io_imem_req_ready = req_ready_c;
  assign io_fault              = fault_q;
  assign io_fault_addr         = fault_addr_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (latency 1 and 3) share stimulus and
// are checked against a reference model with per-instance response scoreboards.
module tb_imem_responder;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic [7:0]  mask;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        fault1, fault3;
  logic [31:0] faddr1, faddr3;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int acc_cnt = 0;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] mem_m [256];
  logic        run_m;
  logic [2:0]  sp_m;
  logic        fault_m;
  logic [31:0] faddr_m;
  logic [31:0] last1, last3;

  imem_responder_if bus1();
  imem_responder_if bus3();

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clock(clk), .reset(rst), .bus(bus1),
    .io_load_valid(load_valid), .io_load_addr(load_addr), .io_load_data(load_data),
    .io_start(start), .io_stall_mask(mask), .io_fault(fault1), .io_fault_addr(faddr1)
  );

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clock(clk), .reset(rst), .bus(bus3),
    .io_load_valid(load_valid), .io_load_addr(load_addr), .io_load_data(load_data),
    .io_start(start), .io_stall_mask(mask), .io_fault(fault3), .io_fault_addr(faddr3)
  );

  assign bus1.io_imem_req_valid     = req_valid;
  assign bus1.io_imem_req_bits_addr = req_addr;
  assign bus3.io_imem_req_valid     = req_valid;
  assign bus3.io_imem_req_bits_addr = req_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic        exp_ready;
    logic        exp_v;
    logic [31:0] exp_d;
    exp_t        e;
    if (rst) begin
      chk("rst_ready1", 32'(bus1.io_imem_req_ready), 32'd0);
      chk("rst_valid1", 32'(bus1.io_imem_resp_valid), 32'd0);
      chk("rst_data1", bus1.io_imem_resp_bits_data, 32'd0);
      chk("rst_valid3", 32'(bus3.io_imem_resp_valid), 32'd0);
      chk("rst_data3", bus3.io_imem_resp_bits_data, 32'd0);
      chk("rst_fault", 32'(fault1), 32'd0);
      chk("rst_faddr", faddr3, 32'd0);
      q1.delete();
      q3.delete();
      run_m   = 1'b0;
      sp_m    = 3'd0;
      fault_m = 1'b0;
      faddr_m = 32'd0;
      last1   = 32'd0;
      last3   = 32'd0;
    end else begin
      // latency-1 response port
      exp_v = (q1.size() > 0) && (q1[0].due == cyc);
      chk("resp_valid1", 32'(bus1.io_imem_resp_valid), 32'(exp_v));
      if (exp_v) begin
        e = q1.pop_front();
        chk("resp_data1", bus1.io_imem_resp_bits_data, e.data);
        last1 = e.data;
      end else begin
        chk("hold_data1", bus1.io_imem_resp_bits_data, last1);
      end
      // latency-3 response port
      exp_v = (q3.size() > 0) && (q3[0].due == cyc);
      chk("resp_valid3", 32'(bus3.io_imem_resp_valid), 32'(exp_v));
      if (exp_v) begin
        e = q3.pop_front();
        chk("resp_data3", bus3.io_imem_resp_bits_data, e.data);
        last3 = e.data;
      end else begin
        chk("hold_data3", bus3.io_imem_resp_bits_data, last3);
      end
      exp_ready = run_m && !mask[sp_m];
      chk("req_ready1", 32'(bus1.io_imem_req_ready), 32'(exp_ready));
      chk("req_ready3", 32'(bus3.io_imem_req_ready), 32'(exp_ready));
      chk("fault1", 32'(fault1), 32'(fault_m));
      chk("fault_addr1", faddr1, faddr_m);
      chk("fault3", 32'(fault3), 32'(fault_m));
      chk("fault_addr3", faddr3, faddr_m);
      if (req_valid && bus1.io_imem_req_ready) acc_cnt++;
      if (req_valid && exp_ready) begin
        if (req_addr[1:0] == 2'b00 && req_addr < 32'd1024) begin
          exp_d = mem_m[req_addr[9:2]];
        end else begin
          exp_d = 32'h0000_0013;
          if (!fault_m) faddr_m = req_addr;
          fault_m = 1'b1;
        end
        q1.push_back('{data: exp_d, due: cyc + 1});
        q3.push_back('{data: exp_d, due: cyc + 3});
      end
      if (load_valid) mem_m[load_addr] = load_data;
      if (!run_m) begin
        if (start) run_m = 1'b1;
      end else begin
        sp_m = sp_m + 3'd1;
      end
    end
  end

  initial begin
    int a0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_addr  = 8'd0;
    load_data  = 32'd0;
    start      = 1'b0;
    mask       = 8'd0;
    req_valid  = 1'b0;
    req_addr   = 32'd0;
    repeat (3) step();
    rst = 1'b0;

    // program load while IDLE; the held request must be ignored
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_addr  = 8'(i);
      load_data  = 32'((i + 1) * 32'h11);
      step();
    end
    load_valid = 1'b0;
    req_valid  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;

    // back-to-back fetches of words 0..3
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(i * 4);
      step();
    end
    req_valid = 1'b0;
    repeat (5) step();

    // isolated fetch
    req_valid = 1'b1;
    req_addr  = 32'd4;
    step();
    req_valid = 1'b0;
    repeat (5) step();

    // stall pattern: two of every eight cycles suppressed
    mask      = 8'b0000_0101;
    a0        = acc_cnt;
    req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_addr = 32'((i % 4) * 4);
      step();
    end
    req_valid = 1'b0;
    mask      = 8'd0;
    step();
    chk("stall_accepts", 32'(acc_cnt - a0), 32'd12);
    repeat (4) step();

    // misaligned then out-of-range fetch
    req_valid = 1'b1;
    req_addr  = 32'h402;
    step();
    req_addr = 32'h400;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    chk("fault_sticky", 32'(fault1), 32'd1);
    chk("fault_first", faddr1, 32'h402);

    // load colliding with a fetch of the same word
    req_valid  = 1'b1;
    req_addr   = 32'd4;
    load_valid = 1'b1;
    load_addr  = 8'd1;
    load_data  = 32'hAA;
    step();
    load_valid = 1'b0;
    step();
    req_valid = 1'b0;
    repeat (5) step();

    // reset with responses in flight
    req_valid = 1'b1;
    req_addr  = 32'd8;
    step();
    req_addr = 32'd12;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'd0;
    repeat (4) step();
    req_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'd12;
    step();
    req_addr = 32'd4;
    step();
    req_valid = 1'b0;
    repeat (6) step();

    chk("drain1", 32'(q1.size()), 32'd0);
    chk("drain3", 32'(q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
